// File: rtl/dcpu_bus_pkg.sv
// Shared bus definitions for the dcpu Wishbone fabric: arbiter states,
// master indices and bus widths.
package dcpu_bus_pkg;

  localparam int unsigned WB_AW    = 32;
  localparam int unsigned WB_DW    = 32;
  localparam int unsigned WB_SW    = 4;
  localparam int unsigned TO_CNT_W = 8;

  // Arbiter states; DRAIN is only reachable when the watchdog is built in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

  localparam logic M_FETCH = 1'b0;
  localparam logic M_LSU   = 1'b1;

  localparam logic [WB_SW-1:0] WB_STB_FULL = 4'b1111;

  // Grant state that belongs to a given master index.
  function automatic arb_state_e grant_state(input logic who);
    return (who == M_LSU) ? GNT1 : GNT0;
  endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Watchdog counter for the Wishbone arbiter: counts granted cycles without a
// slave response and flags the cycle in which the limit is reached.
module wb_arb_timeout
  import dcpu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired_c
);

  localparam logic [TO_CNT_W-1:0] LAST_COUNT = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TO_CNT_W-1:0] count;

  // Wait counter: clear wins over count so a response restarts the window.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      count <= '0;
    end else if (i_count_en) begin
      count <= count + TO_CNT_W'(1);
    end
  end

  // Expiry is only meaningful in a cycle that is itself still waiting.
  assign o_expired_c = i_count_en && (count == LAST_COUNT);

endmodule

// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter (fetcher = m0, LSU = m1).
// Round-robin on ties, grant held for the whole cyc envelope, responses
// routed only to the granted master.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to terminate unanswered
// transactions after TIMEOUT_CYCLES granted cycles with a forced err.
module wb_arbiter
  import dcpu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WB_AW-1:0] i_m0_addr,
  input  logic             i_m0_cyc,
  input  logic [WB_SW-1:0] i_m0_stb,
  output logic [WB_DW-1:0] o_m0_dat,
  output logic             o_m0_ack,
  output logic             o_m0_err,
  input  logic [WB_AW-1:0] i_m1_addr,
  input  logic [WB_DW-1:0] i_m1_dat,
  input  logic             i_m1_we,
  input  logic             i_m1_cyc,
  input  logic [WB_SW-1:0] i_m1_stb,
  output logic [WB_DW-1:0] o_m1_dat,
  output logic             o_m1_ack,
  output logic             o_m1_err,
  output logic [WB_AW-1:0] o_wb_addr,
  output logic [WB_DW-1:0] o_wb_dat,
  output logic             o_wb_we,
  output logic             o_wb_cyc,
  output logic [WB_SW-1:0] o_wb_stb,
  input  logic [WB_DW-1:0] i_wb_dat,
  input  logic             i_wb_ack,
  input  logic             i_wb_err
);

  // The watchdog counter is 8 bits wide, which bounds the usable range.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("wb_arbiter: TIMEOUT_CYCLES must be within 2..255");
  end

  arb_state_e state;
  arb_state_e state_nxt;
  logic       last;
  logic       last_nxt;
  logic       granted;
  logic       expired;

  assign granted = (state == GNT0) || (state == GNT1);

`ifdef WB_ARB_TIMEOUT_EN
  // Watchdog: restarts outside a grant and on any slave response.
  wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clear    (!granted || i_wb_ack || i_wb_err),
    .i_count_en (granted && !i_wb_ack && !i_wb_err),
    .o_expired_c(expired)
  );
`else
  assign expired = 1'b0;
`endif

  // State and round-robin history registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      last  <= M_FETCH;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Next-state: grant from IDLE only, release when the owner drops cyc.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (i_m0_cyc && (!i_m1_cyc || last == M_LSU)) begin
          state_nxt = grant_state(M_FETCH);
          last_nxt  = M_FETCH;
        end else if (i_m1_cyc) begin
          state_nxt = grant_state(M_LSU);
          last_nxt  = M_LSU;
        end
      end
      GNT0: begin
        if (!i_m0_cyc) begin
          state_nxt = IDLE;
        end else if (expired) begin
          state_nxt = DRAIN;
        end
      end
      GNT1: begin
        if (!i_m1_cyc) begin
          state_nxt = IDLE;
        end else if (expired) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
`ifdef WB_ARB_TIMEOUT_EN
        if ((last == M_FETCH) ? !i_m0_cyc : !i_m1_cyc) begin
          state_nxt = IDLE;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output mux: slave driven by the owner, responses only back to the owner.
  always_comb begin
    o_wb_addr = '0;
    o_wb_dat  = '0;
    o_wb_we   = 1'b0;
    o_wb_cyc  = 1'b0;
    o_wb_stb  = '0;
    o_m0_dat  = '0;
    o_m0_ack  = 1'b0;
    o_m0_err  = 1'b0;
    o_m1_dat  = '0;
    o_m1_ack  = 1'b0;
    o_m1_err  = 1'b0;
    case (state)
      GNT0: begin
        o_wb_addr = i_m0_addr;
        o_wb_cyc  = i_m0_cyc;
        o_wb_stb  = i_m0_stb;
        o_m0_dat  = i_wb_dat;
        o_m0_ack  = i_wb_ack;
        o_m0_err  = i_wb_err || expired;
      end
      GNT1: begin
        o_wb_addr = i_m1_addr;
        o_wb_dat  = i_m1_dat;
        o_wb_we   = i_m1_we;
        o_wb_cyc  = i_m1_cyc;
        o_wb_stb  = i_m1_stb;
        o_m1_dat  = i_wb_dat;
        o_m1_ack  = i_wb_ack;
        o_m1_err  = i_wb_err || expired;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: per-cycle vector table plus a hand-written
// watchdog sequence when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter;
  import dcpu_bus_pkg::*;

  localparam logic [31:0] M0_ADDR = 32'h0000_0100;
  localparam logic [31:0] M1_ADDR = 32'h0000_2000;
  localparam logic [31:0] M1_DAT  = 32'h1234_5678;
  localparam logic [3:0]  M1_STB  = 4'b0011;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_m0_addr;
  logic        i_m0_cyc;
  logic [3:0]  i_m0_stb;
  logic [31:0] o_m0_dat;
  logic        o_m0_ack;
  logic        o_m0_err;
  logic [31:0] i_m1_addr;
  logic [31:0] i_m1_dat;
  logic        i_m1_we;
  logic        i_m1_cyc;
  logic [3:0]  i_m1_stb;
  logic [31:0] o_m1_dat;
  logic        o_m1_ack;
  logic        o_m1_err;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_dat;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic [3:0]  o_wb_stb;
  logic [31:0] i_wb_dat;
  logic        i_wb_ack;
  logic        i_wb_err;

  int n_applied = 0;
  int n_bad     = 0;

  always #5 i_clk = ~i_clk;

  wb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_m0_addr(i_m0_addr),
    .i_m0_cyc (i_m0_cyc),
    .i_m0_stb (i_m0_stb),
    .o_m0_dat (o_m0_dat),
    .o_m0_ack (o_m0_ack),
    .o_m0_err (o_m0_err),
    .i_m1_addr(i_m1_addr),
    .i_m1_dat (i_m1_dat),
    .i_m1_we  (i_m1_we),
    .i_m1_cyc (i_m1_cyc),
    .i_m1_stb (i_m1_stb),
    .o_m1_dat (o_m1_dat),
    .o_m1_ack (o_m1_ack),
    .o_m1_err (o_m1_err),
    .o_wb_addr(o_wb_addr),
    .o_wb_dat (o_wb_dat),
    .o_wb_we  (o_wb_we),
    .o_wb_cyc (o_wb_cyc),
    .o_wb_stb (o_wb_stb),
    .i_wb_dat (i_wb_dat),
    .i_wb_ack (i_wb_ack),
    .i_wb_err (i_wb_err)
  );

  // One record per clock cycle: inputs applied in that cycle and the
  // outputs expected in that same cycle. gnt: 0 none, 1 m0, 2 m1.
  typedef struct {
    string       name;
    logic        rst, c0, c1, we1, ack, err;
    logic [31:0] rdat;
    logic [1:0]  gnt;
    logic        wcyc, a0, e0, a1, e1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic rst, c0, c1, we1, ack, err,
                              input logic [31:0] rdat, input logic [1:0] gnt,
                              input logic wcyc, a0, e0, a1, e1);
    vec_t v;
    v.name = n; v.rst = rst; v.c0 = c0; v.c1 = c1; v.we1 = we1;
    v.ack = ack; v.err = err; v.rdat = rdat; v.gnt = gnt;
    v.wcyc = wcyc; v.a0 = a0; v.e0 = e0; v.a1 = a1; v.e1 = e1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    i_reset   = v.rst;
    i_m0_addr = M0_ADDR;
    i_m0_cyc  = v.c0;
    i_m0_stb  = v.c0 ? WB_STB_FULL : 4'b0000;
    i_m1_addr = M1_ADDR;
    i_m1_dat  = M1_DAT;
    i_m1_we   = v.we1;
    i_m1_cyc  = v.c1;
    i_m1_stb  = v.c1 ? M1_STB : 4'b0000;
    i_wb_dat  = v.rdat;
    i_wb_ack  = v.ack;
    i_wb_err  = v.err;
  endtask

  task automatic check_vec(input vec_t v);
    logic [137:0] expv;
    logic [137:0] got;
    logic [31:0]  e_addr, e_dat, e_m0d, e_m1d;
    logic         e_we;
    logic [3:0]   e_stb;
    e_addr = '0; e_dat = '0; e_we = 1'b0; e_stb = '0; e_m0d = '0; e_m1d = '0;
    if (v.gnt == 2'd1) begin
      e_addr = M0_ADDR;
      e_stb  = v.wcyc ? WB_STB_FULL : 4'b0000;
      e_m0d  = v.rdat;
    end else if (v.gnt == 2'd2) begin
      e_addr = M1_ADDR;
      e_dat  = M1_DAT;
      e_we   = v.we1;
      e_stb  = v.wcyc ? M1_STB : 4'b0000;
      e_m1d  = v.rdat;
    end
    expv = {e_addr, e_dat, e_we, v.wcyc, e_stb, e_m0d, v.a0, v.e0, e_m1d, v.a1, v.e1};
    got  = {o_wb_addr, o_wb_dat, o_wb_we, o_wb_cyc, o_wb_stb,
            o_m0_dat, o_m0_ack, o_m0_err, o_m1_dat, o_m1_ack, o_m1_err};
    n_applied++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", v.name, got, expv);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic expv);
    n_applied++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, got, expv);
    end
  endtask

  // Advance one cycle and apply a simple m0-only stimulus.
  task automatic step_m0(input logic c0, input logic ack);
    @(posedge i_clk);
    #1;
    drive(mk("step", 1'b0, c0, 1'b0, 1'b0, ack, 1'b0, 32'hCAFE_0000,
             2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    #3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    //                name            rst c0 c1 we ack err rdat          gnt  wc a0 e0 a1 e1
    vecs.push_back(mk("reset_idle",   0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("fetch_req",    0, 1, 0, 0, 0, 0, 32'hD000_0001,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("fetch_gnt",    0, 1, 0, 0, 0, 0, 32'hD000_0002,  1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("fetch_wait",   0, 1, 0, 0, 0, 0, 32'hD000_0003,  1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("fetch_ack",    0, 1, 0, 0, 1, 0, 32'hDEAD_BEEF,  1, 1, 1, 0, 0, 0));
    vecs.push_back(mk("fetch_drop",   0, 0, 0, 0, 0, 0, 32'hD000_0005,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("idle_stray",   0, 0, 0, 0, 1, 1, 32'hD000_0006,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rst_pulse",    1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("tie_req",      0, 1, 1, 0, 0, 0, 32'hA000_0001,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("tie_gnt1",     0, 1, 1, 0, 0, 0, 32'hA000_0002,  2, 1, 0, 0, 0, 0));
    vecs.push_back(mk("tie_ack1",     0, 1, 1, 0, 1, 0, 32'hA5A5_0001,  2, 1, 0, 0, 1, 0));
    vecs.push_back(mk("tie_drop1",    0, 1, 0, 0, 0, 0, 32'hA000_0004,  2, 0, 0, 0, 0, 0));
    vecs.push_back(mk("tie_idle",     0, 1, 0, 0, 0, 0, 32'hA000_0005,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("tie_gnt0",     0, 1, 0, 0, 0, 0, 32'hA000_0006,  1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("rr_ack0",      0, 1, 1, 0, 1, 0, 32'h0000_0B0B,  1, 1, 1, 0, 0, 0));
    vecs.push_back(mk("rr_drop0",     0, 0, 1, 0, 0, 0, 32'hB000_0002,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rr_idle1",     0, 1, 1, 0, 0, 0, 32'hB000_0003,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rr_wr_gnt1",   0, 1, 1, 1, 0, 0, 32'hB000_0004,  2, 1, 0, 0, 0, 0));
    vecs.push_back(mk("rr_wr_ack1",   0, 1, 1, 1, 1, 0, 32'hB000_0005,  2, 1, 0, 0, 1, 0));
    vecs.push_back(mk("rr_drop1",     0, 1, 0, 1, 0, 0, 32'hB000_0006,  2, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rr_idle2",     0, 1, 1, 0, 0, 0, 32'hB000_0007,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rr_gnt0_we",   0, 1, 1, 1, 1, 0, 32'hB000_0008,  1, 1, 1, 0, 0, 0));
    vecs.push_back(mk("rr_drop0b",    0, 0, 1, 0, 0, 0, 32'hB000_0009,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("lsu_idle",     0, 0, 1, 0, 0, 0, 32'hC000_0001,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("lsu_gnt",      0, 0, 1, 0, 0, 0, 32'hC000_0002,  2, 1, 0, 0, 0, 0));
    vecs.push_back(mk("rst_mid",      1, 0, 1, 0, 0, 0, 32'hC000_0003,  2, 1, 0, 0, 0, 0));
    vecs.push_back(mk("rst_after",    0, 1, 1, 0, 1, 0, 32'hC000_0004,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rst_tie_gnt1", 0, 1, 1, 0, 0, 0, 32'hC000_0005,  2, 1, 0, 0, 0, 0));
    vecs.push_back(mk("lsu_err",      0, 1, 1, 0, 0, 1, 32'hC000_0006,  2, 1, 0, 0, 0, 1));
    vecs.push_back(mk("lsu_drop",     0, 0, 0, 0, 0, 0, 32'hC000_0007,  2, 0, 0, 0, 0, 0));
    vecs.push_back(mk("idle3",        0, 0, 0, 0, 0, 0, 32'hC000_0008,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("b2b_req",      0, 1, 0, 0, 0, 0, 32'hE000_0001,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("b2b_gnt",      0, 1, 0, 0, 1, 0, 32'hE000_0002,  1, 1, 1, 0, 0, 0));
    vecs.push_back(mk("b2b_drop",     0, 0, 0, 0, 0, 0, 32'hE000_0003,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("b2b_idle",     0, 1, 0, 0, 0, 0, 32'hE000_0004,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("b2b_regnt",    0, 1, 0, 0, 0, 0, 32'hE000_0005,  1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("b2b_fin",      0, 0, 0, 0, 0, 0, 32'hE000_0006,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("final_idle",   0, 0, 0, 0, 0, 0, 32'hE000_0007,  0, 0, 0, 0, 0, 0));

    drive(mk("init", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,
             2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (2) @(posedge i_clk);

    foreach (vecs[i]) begin
      @(posedge i_clk);
      #1;
      drive(vecs[i]);
      #3;
      check_vec(vecs[i]);
    end

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never answers: err in the 4th granted cycle, then DRAIN.
    step_m0(1'b1, 1'b0);
    chk1("to_req_cyc", o_wb_cyc, 1'b0);
    for (int g = 1; g <= 4; g++) begin
      step_m0(1'b1, 1'b0);
      chk1($sformatf("to_g%0d_cyc", g), o_wb_cyc, 1'b1);
      chk1($sformatf("to_g%0d_err", g), o_m0_err, (g == 4) ? 1'b1 : 1'b0);
    end
    step_m0(1'b1, 1'b0);
    chk1("to_drain_cyc", o_wb_cyc, 1'b0);
    chk1("to_drain_stb", (o_wb_stb != 4'b0000) ? 1'b1 : 1'b0, 1'b0);
    chk1("to_drain_err", o_m0_err, 1'b0);
    step_m0(1'b1, 1'b1);
    chk1("to_drain_ack", o_m0_ack, 1'b0);
    step_m0(1'b0, 1'b0);
    chk1("to_release_cyc", o_wb_cyc, 1'b0);
    step_m0(1'b0, 1'b0);

    // Ack lands in the expiry cycle: the slave response wins.
    step_m0(1'b1, 1'b0);
    for (int g = 1; g <= 3; g++) begin
      step_m0(1'b1, 1'b0);
      chk1($sformatf("race_g%0d_err", g), o_m0_err, 1'b0);
    end
    step_m0(1'b1, 1'b1);
    chk1("race_ack", o_m0_ack, 1'b1);
    chk1("race_err", o_m0_err, 1'b0);
    step_m0(1'b1, 1'b0);
    chk1("race_still_gnt", o_wb_cyc, 1'b1);
    step_m0(1'b0, 1'b0);
    step_m0(1'b0, 1'b0);
    chk1("race_idle", o_wb_cyc, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_bad);
    $finish;
  end

endmodule
